// File: rtl/axi_ram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_ram_slave_if
//   AXI3 signal bundle between a bus master and axi_ram_slave.
//   Channels carried:
//     AR : arid, araddr, arlen, arsize, arburst, arvalid / arready
//     R  : rid, rdata, rresp, rlast, rvalid / rready
//     AW : awid, awaddr, awlen, awsize, awburst, awvalid / awready
//     W  : wid, wdata, wstrb, wlast, wvalid / wready
//     B  : bid, bresp, bvalid / bready
//   Modports: slave (the RAM side), master (the requester side).
//   No lock/cache/prot signals exist here; those stay unconnected upstream.
// ---------------------------------------------------------------------------
interface axi_ram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// ---------------------------------------------------------------------------
// axi_ram_slave
//   AXI3 slave backed by a 2^(ADDR_WIDTH-2) x 32-bit RAM. Independent read
//   and write engines; one beat per cycle on each channel.
//   Ports:
//     aclk    in  clock, all state changes on its rising edge
//     aresetn in  asynchronous active-low reset (RAM contents are kept)
//     s_axi       axi_ram_slave_if.slave, the five AXI3 channels
//   Only the low ADDR_WIDTH byte-address bits are decoded (higher bits alias).
// ---------------------------------------------------------------------------
module axi_ram_slave #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic            aclk,
  input  logic            aresetn,
  axi_ram_slave_if.slave  s_axi
);
  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [31:0] r_mem [DEPTH];

  // ---------------- read engine state ----------------
  rstate_t                r_rstate, w_rstate_next;
  logic                   r_arready;
  logic [3:0]             r_arid;
  logic [ADDR_WIDTH-1:0]  r_raddr;
  logic [7:0]             r_rlen, r_rcnt;
  logic [2:0]             r_rsize;
  logic [1:0]             r_rburst;
  logic [31:0]            r_rdata;
  logic                   r_rlast;

  // ---------------- write engine state ----------------
  wstate_t                r_wstate, w_wstate_next;
  logic                   r_awready;
  logic [3:0]             r_awid;
  logic [ADDR_WIDTH-1:0]  r_waddr;
  logic [7:0]             r_wlen, r_wcnt;
  logic [2:0]             r_wsize;
  logic [1:0]             r_wburst;
  logic                   r_wover;   // more beats arrived than awlen+1
  logic [1:0]             r_bresp;

  logic                   w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic [ADDR_WIDTH-1:0]  w_raddr_next, w_waddr_next;

  assign w_ar_hs = s_axi.arvalid & r_arready;
  assign w_r_hs  = (r_rstate == R_DATA) & s_axi.rready;
  assign w_aw_hs = s_axi.awvalid & r_awready;
  assign w_w_hs  = (r_wstate == W_DATA) & s_axi.wvalid;
  assign w_b_hs  = (r_wstate == W_RESP) & s_axi.bready;

  // FIXED bursts hold the address; every other burst code steps by the beat
  // size. The add is ADDR_WIDTH bits wide, so it wraps at the memory depth.
  assign w_raddr_next = (r_rburst == 2'b00) ? r_raddr
                      : r_raddr + (ADDR_WIDTH'(1) << r_rsize);
  assign w_waddr_next = (r_wburst == 2'b00) ? r_waddr
                      : r_waddr + (ADDR_WIDTH'(1) << r_wsize);

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_next;
      // Registered ready: it follows the state we are about to enter.
      r_arready <= (w_rstate_next == R_IDLE);
    end
  end

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs)            w_rstate_next = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast)  w_rstate_next = R_IDLE;
      default:                         w_rstate_next = R_IDLE;
    endcase
  end

  // Read datapath. rdata is loaded straight from the RAM on the AR handshake
  // and on every accepted non-final beat, so the next word is ready with no
  // bubble. Reading r_mem here with nonblocking semantics gives the pre-write
  // value when a W beat hits the same word on the same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_arid   <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rdata  <= '0;
      r_rlast  <= 1'b0;
    end else if (w_ar_hs) begin
      r_arid   <= s_axi.arid;
      r_raddr  <= s_axi.araddr[ADDR_WIDTH-1:0];
      r_rlen   <= s_axi.arlen;
      r_rcnt   <= '0;
      r_rsize  <= s_axi.arsize;
      r_rburst <= s_axi.arburst;
      r_rdata  <= r_mem[s_axi.araddr[ADDR_WIDTH-1:2]];
      r_rlast  <= (s_axi.arlen == 8'd0);
    end else if (w_r_hs) begin
      if (!r_rlast) begin
        r_raddr <= w_raddr_next;
        r_rcnt  <= r_rcnt + 8'd1;
        r_rdata <= r_mem[w_raddr_next[ADDR_WIDTH-1:2]];
        r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
      end else begin
        r_rlast <= 1'b0;
      end
    end
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_next;
      r_awready <= (w_wstate_next == W_IDLE);
    end
  end

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs)                 w_wstate_next = W_DATA;
      W_DATA:  if (w_w_hs && s_axi.wlast)   w_wstate_next = W_RESP;
      W_RESP:  if (w_b_hs)                  w_wstate_next = W_IDLE;
      default:                              w_wstate_next = W_IDLE;
    endcase
  end

  // Write datapath. r_wcnt stops at awlen and r_wover records any extra
  // beats, so a late wlast can never wrap the counter back to a match.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awid   <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wover  <= 1'b0;
      r_bresp  <= 2'b00;
    end else if (w_aw_hs) begin
      r_awid   <= s_axi.awid;
      r_waddr  <= s_axi.awaddr[ADDR_WIDTH-1:0];
      r_wlen   <= s_axi.awlen;
      r_wcnt   <= '0;
      r_wsize  <= s_axi.awsize;
      r_wburst <= s_axi.awburst;
      r_wover  <= 1'b0;
    end else if (w_w_hs) begin
      r_waddr <= w_waddr_next;
      if (s_axi.wlast)
        r_bresp <= ((r_wcnt == r_wlen) && !r_wover) ? 2'b00 : 2'b10;
      else if (r_wcnt == r_wlen)
        r_wover <= 1'b1;
      else
        r_wcnt  <= r_wcnt + 8'd1;
    end
  end

  // RAM write port with byte enables; no reset so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.wstrb[b])
          r_mem[r_waddr[ADDR_WIDTH-1:2]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- outputs ----------------
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = (r_rstate == R_DATA);
  assign s_axi.rid     = r_arid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.awready = r_awready;
  assign s_axi.wready  = (r_wstate == W_DATA);
  assign s_axi.bvalid  = (r_wstate == W_RESP);
  assign s_axi.bid     = r_awid;
  assign s_axi.bresp   = r_bresp;

  // Undecoded address bits and wid are intentionally ignored.
  logic w_unused;
  assign w_unused = &{1'b0, s_axi.araddr[31:ADDR_WIDTH],
                      s_axi.awaddr[31:ADDR_WIDTH], s_axi.wid};
endmodule

// File: tb/tb_axi_ram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_ram_slave
//   Self-checking bench for axi_ram_slave. A word-array reference memory is
//   updated from the AXI burst rules; reads are compared beat by beat.
// ---------------------------------------------------------------------------
module tb_axi_ram_slave;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << (AW - 2);

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_ram_slave_if bus();
  axi_ram_slave #(.ADDR_WIDTH(AW)) dut (.aclk(aclk), .aresetn(aresetn), .s_axi(bus));

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  logic [31:0] rd_q [$];
  bit          rr_pat [$];

  typedef struct {
    logic [31:0] addr_a;
    logic [31:0] init;
    logic [31:0] addr_b;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expv;
  } merge_vec_t;
  merge_vec_t vecs [6];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  function automatic logic [AW-1:0] adv(logic [AW-1:0] a, logic [2:0] size, logic [1:0] burst);
    if (burst == 2'b00) return a;
    return a + AW'(32'd1 << size);
  endfunction

  function automatic void model_write(logic [AW-1:0] a, logic [31:0] d, logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[a[AW-1:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic bit next_rdy(bit rnd);
    if (rr_pat.size() > 0) return rr_pat.pop_front();
    return rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // Write burst of nbeats beats taken from wd_q/ws_q; wlast on the final beat.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats);
    logic [AW-1:0] a;
    logic [1:0]    exp_resp;
    int g;
    int d;
    a = addr[AW-1:0];
    exp_resp = (nbeats == int'(len) + 1) ? 2'b00 : 2'b10;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    g = 0;
    while (bus.awready !== 1'b1 && g < 50) begin tick(); g++; end
    chk("awready", 32'(bus.awready), 32'd1);
    if (bus.awready !== 1'b1) begin bus.awvalid = 1'b0; return; end
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wd_q[i]; bus.wstrb = ws_q[i];
      bus.wlast = (i == nbeats - 1); bus.wid = id;
      g = 0;
      while (bus.wready !== 1'b1 && g < 50) begin tick(); g++; end
      chk("wready", 32'(bus.wready), 32'd1);
      if (bus.wready !== 1'b1) begin bus.wvalid = 1'b0; bus.wlast = 1'b0; return; end
      tick();
      model_write(a, wd_q[i], ws_q[i]);
      a = adv(a, size, burst);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    d = $urandom_range(0, 2);
    for (int i = 0; i <= d; i++) begin
      chk("bvalid", 32'(bus.bvalid), 32'd1);
      chk("bid", 32'(bus.bid), 32'(id));
      chk("bresp", 32'(bus.bresp), 32'(exp_resp));
      if (i < d) tick();
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("b_done_bvalid", 32'(bus.bvalid), 32'd0);
    chk("b_done_awready", 32'(bus.awready), 32'd1);
    $display("WRITE id=%0d addr=%h len=%0d size=%0d burst=%0d beats=%0d bresp=%0d",
             id, addr, len, size, burst, nbeats, exp_resp);
  endtask

  // Read burst; every visible beat (stalled or not) is compared to the model.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit rnd);
    logic [AW-1:0] a;
    int  beat;
    int  g;
    bit  took;
    a = addr[AW-1:0];
    beat = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    g = 0;
    while (bus.arready !== 1'b1 && g < 50) begin tick(); g++; end
    chk("arready", 32'(bus.arready), 32'd1);
    if (bus.arready !== 1'b1) begin bus.arvalid = 1'b0; return; end
    tick();
    bus.arvalid = 1'b0;
    chk("r_latency", 32'(bus.rvalid), 32'd1);
    bus.rready = next_rdy(rnd);
    g = 0;
    while (beat <= int'(len) && g < 4000) begin
      if (bus.rvalid !== 1'b1) begin
        chk("rvalid_in_burst", 32'(bus.rvalid), 32'd1);
        break;
      end
      chk("rdata", bus.rdata, mdl[a[AW-1:2]]);
      chk("rid", 32'(bus.rid), 32'(id));
      chk("rlast", 32'(bus.rlast), (beat == int'(len)) ? 32'd1 : 32'd0);
      took = bus.rready;
      if (took) rd_q.push_back(bus.rdata);
      tick();
      g++;
      if (took) begin beat++; a = adv(a, size, burst); end
      bus.rready = next_rdy(rnd);
    end
    bus.rready = 1'b0;
    chk("r_done_rvalid", 32'(bus.rvalid), 32'd0);
    chk("r_done_arready", 32'(bus.arready), 32'd1);
    $display("READ  id=%0d addr=%h len=%0d size=%0d burst=%0d beats=%0d", id, addr, len, size, burst, beat);
  endtask

  initial begin
    logic [31:0] old44;
    logic [7:0]  rl;
    int          nb;

    vecs[0] = '{32'h200, 32'h11223344, 32'h200, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD};
    vecs[1] = '{32'h204, 32'h00000000, 32'h204, 32'hFFFFFFFF, 4'b1000, 32'hFF000000};
    vecs[2] = '{32'h208, 32'hDEADBEEF, 32'h208, 32'h12345678, 4'b0000, 32'hDEADBEEF};
    vecs[3] = '{32'h20C, 32'hCAFEF00D, 32'h20C, 32'h01020304, 4'b0011, 32'hCAFE0304};
    vecs[4] = '{32'h210, 32'h55555555, 32'h210, 32'h9ABCDEF0, 4'b1111, 32'h9ABCDEF0};
    vecs[5] = '{32'h214, 32'h00000000, 32'h80000614, 32'h77777777, 4'b1111, 32'h77777777};

    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;

    // ---- reset values ----
    tick(); tick();
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready",  32'(bus.wready),  32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rlast",   32'(bus.rlast),   32'd0);
    chk("rst_rid",     32'(bus.rid),     32'd0);
    chk("rst_bid",     32'(bus.bid),     32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    chk("rst_rresp",   32'(bus.rresp),   32'd0);
    chk("rst_bresp",   32'(bus.bresp),   32'd0);
    aresetn = 1'b1;
    chk("rel_arready_pre_edge", 32'(bus.arready), 32'd0);
    tick();
    chk("rel_arready", 32'(bus.arready), 32'd1);
    chk("rel_awready", 32'(bus.awready), 32'd1);
    chk("rel_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rel_bvalid",  32'(bus.bvalid),  32'd0);
    $display("RESET released, ready flags up");

    // ---- fill the whole RAM with a 256-beat burst, then read it back ----
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i < DEPTH; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
    do_write(4'd0, 32'h0, 8'd255, 3'd2, 2'b01, DEPTH);
    do_read(4'd0, 32'h0, 8'd255, 3'd2, 2'b01, 1'b1);

    // ---- basic INCR burst ----
    wd_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(4'd3, 32'h100, 8'd3, 3'd2, 2'b01, 4);
    rd_q.delete();
    do_read(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0);
    chk("incr_count", 32'(rd_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++)
      chk("incr_data", rd_q[i], 32'hA0 + 32'(i));

    // ---- stalled read with rready 1,0,0,1,1 ----
    rr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rd_q.delete();
    do_read(4'd6, 32'h104, 8'd2, 3'd2, 2'b01, 1'b0);
    chk("stall_count", 32'(rd_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < rd_q.size(); i++)
      chk("stall_data", rd_q[i], 32'hA1 + 32'(i));

    // ---- byte-lane merge and aliasing table ----
    for (int i = 0; i < 6; i++) begin
      wd_q = '{vecs[i].init}; ws_q = '{4'hF};
      do_write(4'd1, vecs[i].addr_a, 8'd0, 3'd2, 2'b01, 1);
      wd_q = '{vecs[i].data}; ws_q = '{vecs[i].strb};
      do_write(4'd2, vecs[i].addr_b, 8'd0, 3'd2, 2'b01, 1);
      rd_q.delete();
      do_read(4'd3, vecs[i].addr_a, 8'd0, 3'd2, 2'b01, 1'b0);
      chk("merge_count", 32'(rd_q.size()), 32'd1);
      if (rd_q.size() > 0) chk($sformatf("merge[%0d]", i), rd_q[0], vecs[i].expv);
    end

    // ---- FIXED burst keeps hitting one word ----
    wd_q = '{32'h1, 32'h2}; ws_q = '{4'hF, 4'hF};
    do_write(4'd4, 32'h300, 8'd1, 3'd2, 2'b00, 2);
    rd_q.delete();
    do_read(4'd4, 32'h300, 8'd3, 3'd2, 2'b00, 1'b1);
    chk("fixed_count", 32'(rd_q.size()), 32'd4);
    if (rd_q.size() > 0) chk("fixed_word", rd_q[0], 32'h2);

    // ---- early wlast with a colliding read on the second beat ----
    old44 = mdl[32'h44 >> 2];
    bus.awid = 4'd7; bus.awaddr = 32'h40; bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.awvalid = 1'b1;
    chk("col_awready", 32'(bus.awready), 32'd1);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'h11110001; bus.wstrb = 4'hF; bus.wlast = 1'b0;
    chk("col_wready1", 32'(bus.wready), 32'd1);
    tick();
    bus.wdata = 32'h22220002; bus.wlast = 1'b1;
    bus.arid = 4'd2; bus.araddr = 32'h44; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arvalid = 1'b1; bus.rready = 1'b0;
    chk("col_wready2", 32'(bus.wready), 32'd1);
    chk("col_arready", 32'(bus.arready), 32'd1);
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
    chk("col_rvalid", 32'(bus.rvalid), 32'd1);
    chk("col_rdata_old", bus.rdata, old44);
    chk("col_rlast", 32'(bus.rlast), 32'd1);
    chk("col_rid", 32'(bus.rid), 32'd2);
    chk("col_bvalid", 32'(bus.bvalid), 32'd1);
    chk("col_bresp", 32'(bus.bresp), 32'd2);
    chk("col_bid", 32'(bus.bid), 32'd7);
    bus.rready = 1'b1; bus.bready = 1'b1;
    tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    chk("col_rvalid_done", 32'(bus.rvalid), 32'd0);
    chk("col_bvalid_done", 32'(bus.bvalid), 32'd0);
    $display("COLLIDE write 0x40 two beats early wlast, read 0x44 same edge old=%h", old44);
    model_write(AW'(32'h40), 32'h11110001, 4'hF);
    model_write(AW'(32'h44), 32'h22220002, 4'hF);
    do_read(4'd9, 32'h40, 8'd2, 3'd2, 2'b01, 1'b0);

    // ---- late wlast ----
    wd_q = '{32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003}; ws_q = '{4'hF, 4'hF, 4'hF};
    do_write(4'd8, 32'h180, 8'd1, 3'd2, 2'b01, 3);
    do_read(4'd8, 32'h180, 8'd2, 3'd2, 2'b01, 1'b0);

    // ---- randomized traffic against the reference memory ----
    for (int t = 0; t < 40; t++) begin
      rl = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        nb = int'(rl) + 1;
        case ($urandom_range(0, 7))
          0: nb = int'(rl) + 2;
          1: if (rl > 0) nb = int'(rl);
          default: ;
        endcase
        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < nb; i++) begin
          wd_q.push_back($urandom);
          ws_q.push_back(4'($urandom_range(0, 15)));
        end
        do_write(4'($urandom_range(0, 15)), $urandom, rl, 3'($urandom_range(0, 2)),
                 2'($urandom_range(0, 2)), nb);
      end else begin
        do_read(4'($urandom_range(0, 15)), $urandom, rl, 3'($urandom_range(0, 2)),
                2'($urandom_range(0, 2)), 1'b1);
      end
    end

    // ---- reset during the 2nd beat of a len=7 read ----
    bus.arid = 4'd1; bus.araddr = 32'h100; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arvalid = 1'b1; bus.rready = 1'b1;
    chk("mrst_arready", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
    tick();
    chk("mrst_beat2_valid", 32'(bus.rvalid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("mrst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("mrst_arready", 32'(bus.arready), 32'd0);
    chk("mrst_rlast", 32'(bus.rlast), 32'd0);
    chk("mrst_rdata", bus.rdata, 32'd0);
    bus.rready = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    chk("mrst_rel_pre_edge", 32'(bus.arready), 32'd0);
    tick();
    chk("mrst_rel_arready", 32'(bus.arready), 32'd1);
    chk("mrst_rel_awready", 32'(bus.awready), 32'd1);
    $display("RESET mid-burst, recovered");
    do_read(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1);
    do_read(4'd3, 32'h0, 8'd15, 3'd2, 2'b01, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
